// File: rtl/uwire_arb_pkg.sv
// Shared types and helpers for the uwire bus arbiter: FSM state encoding
// and a one-hot decoder sized for the largest legal requester count.
package uwire_arb_pkg;

    localparam int unsigned MAX_NREQ = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Bits at or above nreq stay clear, so callers may slice the low nreq bits.
    function automatic logic [MAX_NREQ-1:0] onehot_f(input int unsigned index,
                                                     input int unsigned nreq);
        logic [MAX_NREQ-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_NREQ; i++) begin
            if (i == index && i < nreq) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/uwire_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// ptr, wrapping modulo NREQ (works for non-power-of-two NREQ).
module uwire_rr_pick
    import uwire_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] winner
);

    localparam int unsigned PW = $clog2(NREQ);

    always_comb begin
        int unsigned      idx;
        logic [PW-1:0]    idx_w;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = PW'(idx);
            if (!any && req[idx_w]) begin
                any    = 1'b1;
                winner = idx_w;
            end
        end
    end

endmodule

// File: rtl/uwire_bus_arbiter.sv
// Round-robin owner sequencer for a single-driver shared bus: grants one
// requester at a time, caps tenure at MAXHOLD beats, and leaves a one-cycle gap.
module uwire_bus_arbiter
    import uwire_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAXHOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic                    bus_ready,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    bus_valid,
    output logic [DW-1:0]           bus_data,
    output logic [$clog2(NREQ)-1:0] bus_owner
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAXHOLD + 1);

    if (MAXHOLD == 0) begin : g_bad_maxhold
        $fatal(1, "uwire_bus_arbiter: MAXHOLD must be at least 1");
    end
    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $fatal(1, "uwire_bus_arbiter: NREQ must be in 2..16");
    end

    arb_state_t            state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  pick_any;
    logic [PW-1:0]         pick_idx;
    logic [MAX_NREQ-1:0]   pick_oh;
    logic                  owner_req;
    logic                  beat_acc;
    logic                  hold_done;
    logic [DW-1:0]         slot [NREQ];

    uwire_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign pick_oh = onehot_f(32'(pick_idx), NREQ);

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DW +: DW];
    end

    // A beat dropped in the same cycle as req falls out naturally: bus_valid
    // follows req[owner], so no ack and no count on the release cycle.
    assign owner_req = req[owner_q];
    assign bus_valid = (state_q == BUSY) && owner_req;
    assign beat_acc  = bus_valid && bus_ready;
    assign hold_done = beat_acc && (cnt_q == CW'(MAXHOLD - 1));

    assign gnt       = gnt_q;
    assign ack       = gnt_q & req & {NREQ{bus_ready}};
    assign bus_owner = owner_q;

    // The one and only driver of the shared net.
    uwire [DW-1:0] bus_net;
    assign bus_net  = bus_valid ? slot[owner_q] : '0;
    assign bus_data = bus_net;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, TURN: begin
                if (pick_any) begin
                    state_d = BUSY;
                    gnt_d   = pick_oh[NREQ-1:0];
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                end
            end
            BUSY: begin
                if (!owner_req || hold_done) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                    owner_d = '0;
                    cnt_d   = '0;
                end else if (beat_acc) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= PW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_valid_owned: assert property (@(posedge clk) disable iff (!rst_n)
        bus_valid |-> gnt_q[owner_q]);
    a_turn_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != BUSY) |-> (gnt_q == '0 && !bus_valid));

    if (NREQ < MAX_NREQ) begin : g_oh_range
        a_pick_in_range: assert property (@(posedge clk) disable iff (!rst_n)
            pick_oh[MAX_NREQ-1:NREQ] == '0);
    end

endmodule

// File: tb/tb_uwire_bus_arbiter.sv
// Directed bench for uwire_bus_arbiter (NREQ=4, DW=8, MAXHOLD=4): inputs are
// driven on the falling edge and outputs sampled 1ns later.
module tb_uwire_bus_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned MAXHOLD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] req_data = 32'h43322110;
    logic              bus_ready = 1'b0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              bus_valid;
    logic [DW-1:0]     bus_data;
    logic [1:0]        bus_owner;

    int tests = 0;
    int fails = 0;

    // {gnt, ack, bus_valid, bus_owner, bus_data}
    logic [18:0] obs;
    assign obs = {gnt, ack, bus_valid, bus_owner, bus_data};

    always #5 clk = ~clk;

    uwire_bus_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .MAXHOLD (MAXHOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .bus_ready (bus_ready),
        .gnt       (gnt),
        .ack       (ack),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_owner (bus_owner)
    );

    function automatic logic [18:0] pk(input logic [3:0] g, input logic [3:0] a,
                                       input logic v, input logic [1:0] o,
                                       input logic [7:0] d);
        return {g, a, v, o, d};
    endfunction

    task automatic fresh_reset();
        rst_n     = 1'b0;
        req       = '0;
        bus_ready = 1'b0;
        req_data  = 32'h43322110;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        rst_n = 1'b0; req = 4'b1111; bus_ready = 1'b1; req_data = 32'h43322110;
        @(negedge clk); #1;
        e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_hold got %h exp %h", obs, e); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        e = pk(4'b0001, 4'b0001, 1'b1, 2'd0, 8'h10);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_release got %h exp %h", obs, e); end
    endtask

    task automatic test_hold_limit();
        logic [18:0] e;
        fresh_reset();
        req_data[7:0] = 8'hA5; req = 4'b0001; bus_ready = 1'b1;
        #1;
        e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL hold_idle got %h exp %h", obs, e); end
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk); #1;
                e = pk(4'b0001, 4'b0001, 1'b1, 2'd0, 8'hA5);
                tests++;
                if (obs !== e) begin fails++; $display("FAIL hold_beat p%0d b%0d got %h exp %h", p, b, obs, e); end
            end
            @(negedge clk); #1;
            e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL hold_turn p%0d got %h exp %h", p, obs, e); end
        end
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [18:0] e;
        logic [3:0]  oh;
        logic [1:0]  ob;
        logic [7:0]  d;
        int          nb;
        fresh_reset();
        req = 4'b1111; bus_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ob = 2'(k % 4);
            oh = 4'b0001 << ob;
            d  = 8'(8'h10 + 8'h11 * ob);
            nb = (k < 4) ? 4 : 1;
            for (int b = 0; b < nb; b++) begin
                @(negedge clk); #1;
                e = pk(oh, oh, 1'b1, ob, d);
                tests++;
                if (obs !== e) begin fails++; $display("FAIL rr_beat k%0d b%0d got %h exp %h", k, b, obs, e); end
            end
            if (k < 4) begin
                @(negedge clk); #1;
                e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
                tests++;
                if (obs !== e) begin fails++; $display("FAIL rr_turn k%0d got %h exp %h", k, obs, e); end
            end
        end
    endtask

    task automatic test_early_release();
        logic [18:0] e;
        fresh_reset();
        req = 4'b1100; bus_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); #1;
            e = pk(4'b0100, 4'b0100, 1'b1, 2'd2, 8'h32);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL early_beat b%0d got %h exp %h", b, obs, e); end
        end
        @(negedge clk);
        req = 4'b1001;
        #1;
        e = pk(4'b0100, 4'b0000, 1'b0, 2'd2, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL early_drop got %h exp %h", obs, e); end
        @(negedge clk); #1;
        e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL early_turn got %h exp %h", obs, e); end
        // ptr=2 after the release, so 3 must beat 0
        @(negedge clk); #1;
        e = pk(4'b1000, 4'b1000, 1'b1, 2'd3, 8'h43);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL early_regrant got %h exp %h", obs, e); end
    endtask

    task automatic test_backpressure();
        logic [18:0] e;
        fresh_reset();
        req = 4'b0010; bus_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            e = pk(4'b0010, 4'b0000, 1'b1, 2'd1, 8'h21);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL bp_stall i%0d got %h exp %h", i, obs, e); end
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            bus_ready = 1'b1;
            #1;
            e = pk(4'b0010, 4'b0010, 1'b1, 2'd1, 8'h21);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL bp_beat b%0d got %h exp %h", b, obs, e); end
        end
        @(negedge clk); #1;
        e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL bp_turn got %h exp %h", obs, e); end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); #1;
            e = pk(4'b0010, 4'b0010, 1'b1, 2'd1, 8'h21);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL bp_regrant b%0d got %h exp %h", b, obs, e); end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        e = pk(4'b0010, 4'b0000, 1'b0, 2'd1, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL simul_drop got %h exp %h", obs, e); end
        @(negedge clk); #1;
        e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL simul_turn got %h exp %h", obs, e); end
        @(negedge clk); #1;
        tests++;
        if (obs !== e) begin fails++; $display("FAIL simul_idle got %h exp %h", obs, e); end
    endtask

    task automatic test_reset_mid_busy();
        logic [18:0] e;
        fresh_reset();
        req = 4'b1000; bus_ready = 1'b1;
        @(negedge clk); #1;
        e = pk(4'b1000, 4'b1000, 1'b1, 2'd3, 8'h43);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL mid_busy got %h exp %h", obs, e); end
        req = 4'b1010;
        #2;
        rst_n = 1'b0;
        #1;
        e = pk(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL mid_async got %h exp %h", obs, e); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (obs !== e) begin fails++; $display("FAIL mid_released got %h exp %h", obs, e); end
        @(negedge clk); #1;
        e = pk(4'b0010, 4'b0010, 1'b1, 2'd1, 8'h21);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL mid_lowest got %h exp %h", obs, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hold_limit();
        test_round_robin();
        test_early_release();
        test_backpressure();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
